// File: rtl/msg_byte_serializer.sv
// Serializes a DATASIZE-bit message into bytes (MSB byte first) for uart_tx,
// optionally skipping NUL pad bytes, and reports done/err per message.
module msg_byte_serializer #(
  parameter int DATASIZE    = 128,
  parameter int SKIP_NUL    = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [DATASIZE-1:0] data,
  input  logic                tx_busy,
  output logic                tx_en,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          state
);

  localparam int NBYTES = DATASIZE / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4,
    S_ABORT     = 3'd5
  } state_t;

  state_t              r_state, w_state_next;
  logic [DATASIZE-1:0] r_shreg, w_shreg_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;
  logic [TW-1:0]       r_tmo, w_tmo_next;
  logic                r_tx_en, w_tx_en_next;
  logic [7:0]          r_tx_data, w_tx_data_next;
  logic                r_done, w_done_next;
  logic                r_err, w_err_next;

  logic [7:0]          w_top;
  logic                w_top_nul;
  logic                w_last;
  logic                w_tmo_hit;

  assign w_top     = r_shreg[DATASIZE-1 -: 8];
  assign w_top_nul = (SKIP_NUL != 0) && (w_top == 8'h00);
  assign w_last    = (r_cnt == CW'(1));
  // The WAIT_ACK entry cycle counts as the first waited cycle.
  assign w_tmo_hit = (r_tmo == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_next = S_SEND;
      S_SEND: begin
        if (w_top_nul)     w_state_next = w_last ? S_FINISH : S_SEND;
        else if (!tx_busy) w_state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy)        w_state_next = S_WAIT_DONE;
        else if (w_tmo_hit) w_state_next = S_ABORT;
      end
      S_WAIT_DONE: if (!tx_busy) w_state_next = w_last ? S_FINISH : S_SEND;
      S_FINISH:    w_state_next = S_IDLE;
      S_ABORT:     w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shreg_next   = r_shreg;
    w_cnt_next     = r_cnt;
    w_tmo_next     = r_tmo;
    w_tx_en_next   = 1'b0;
    w_tx_data_next = r_tx_data;
    w_done_next    = (w_state_next == S_FINISH);
    w_err_next     = (w_state_next == S_ABORT);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shreg_next = data;
          w_cnt_next   = CW'(NBYTES);
        end
      end
      S_SEND: begin
        if (w_top_nul) begin
          w_shreg_next = r_shreg << 8;
          w_cnt_next   = r_cnt - CW'(1);
        end else if (!tx_busy) begin
          w_tx_data_next = w_top;
          w_tx_en_next   = 1'b1;
          w_tmo_next     = '0;
        end
      end
      S_WAIT_ACK: begin
        if (!tx_busy) w_tmo_next = r_tmo + TW'(1);
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_shreg_next = r_shreg << 8;
          w_cnt_next   = r_cnt - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_shreg   <= w_shreg_next;
      r_cnt     <= w_cnt_next;
      r_tmo     <= w_tmo_next;
      r_tx_en   <= w_tx_en_next;
      r_tx_data <= w_tx_data_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
    end
  end

  assign tx_en   = r_tx_en;
  assign tx_data = r_tx_data;
  assign done    = r_done;
  assign err     = r_err;
  assign busy    = (r_state != S_IDLE);
  assign state   = r_state;

endmodule

// File: tb/tb_msg_byte_serializer.sv
// Directed bench for msg_byte_serializer: one instance with NUL skipping, one
// without, each driving a uart_tx model (busy 1 cycle after tx_en, for 10 cycles).
module tb_msg_byte_serializer;

  localparam logic [127:0] MSG_CALC = {32'h0, "CALCULATOR", 8'h0A, 8'h0D};
  localparam logic [127:0] MSG_A    = {8'h41, 120'h0};

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0, start0 = 1'b0;
  logic [127:0] data = '0;
  logic         tx_busy, tx_busy0;
  logic         tx_en, tx_en0;
  logic [7:0]   tx_data, tx_data0;
  logic         busy, busy0, done, done0, err, err0;
  logic [2:0]   state, state0;

  msg_byte_serializer #(.DATASIZE(128), .SKIP_NUL(1), .ACK_TIMEOUT(15)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .data(data), .tx_busy(tx_busy),
    .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .done(done), .err(err), .state(state));

  msg_byte_serializer #(.DATASIZE(128), .SKIP_NUL(0), .ACK_TIMEOUT(15)) u_dut0 (
    .clk(clk), .resetn(resetn), .start(start0), .data(data), .tx_busy(tx_busy0),
    .tx_en(tx_en0), .tx_data(tx_data0), .busy(busy0), .done(done0), .err(err0), .state(state0));

  // uart_tx models
  int   bcnt = 0, bcnt0 = 0;
  logic uart_off = 1'b0, force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_en && !uart_off) bcnt <= 10;
    else if (bcnt > 0)      bcnt <= bcnt - 1;
  end
  always @(posedge clk) begin
    if (tx_en0)         bcnt0 <= 10;
    else if (bcnt0 > 0) bcnt0 <= bcnt0 - 1;
  end
  assign tx_busy  = force_busy || (bcnt != 0);
  assign tx_busy0 = (bcnt0 != 0);

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] obs0_q[$];
  int en_cnt = 0, done_cnt = 0, err_cnt = 0, en_while_busy = 0;
  logic [7:0] calc_bytes [12] = '{8'h43, 8'h41, 8'h4C, 8'h43, 8'h55, 8'h4C,
                                  8'h41, 8'h54, 8'h4F, 8'h52, 8'h0A, 8'h0D};

  always @(negedge clk) begin
    if (tx_en) begin
      obs_q.push_back(tx_data);
      en_cnt <= en_cnt + 1;
      if (tx_busy) en_while_busy <= en_while_busy + 1;
    end
    if (tx_en0) obs0_q.push_back(tx_data0);
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input logic [7:0] got[$]);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic load_exp(input int n_nul);
    exp_q.delete();
    for (int i = 0; i < n_nul; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 12; i++)    exp_q.push_back(calc_bytes[i]);
  endtask

  // Leaves the caller at the negedge one cycle after the start cycle (k=1).
  task automatic start_msg(input logic [127:0] d);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_end(input int k_in, input int max, output int k_out);
    int k = k_in;
    while (!(done || err) && k < max) begin
      @(negedge clk);
      k++;
    end
    k_out = k;
  endtask

  int k, en0, dn0, er0;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: CALCULATOR with leading NULs skipped
    obs_q.delete(); load_exp(0);
    dn0 = done_cnt; er0 = err_cnt;
    start_msg(MSG_CALC);
    check("t1_state_send", state, 1);
    repeat (5) @(negedge clk);
    check("t1_first_en", tx_en, 1);
    check("t1_first_byte", tx_data, 8'h43);
    wait_end(6, 400, k);
    check("t1_done", done, 1);
    check("t1_done_cycle", k, 161);
    @(negedge clk);
    check_seq("t1_seq", obs_q);
    check("t1_done_cnt", done_cnt - dn0, 1);
    check("t1_err_cnt", err_cnt - er0, 0);
    check("t1_busy_after", busy, 0);
    check("t1_state_after", state, 0);

    // 2: same data, NUL bytes transmitted
    obs0_q.delete(); load_exp(4);
    data = MSG_CALC; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    check("t2_first_en", tx_en0, 1);
    check("t2_first_byte", tx_data0, 8'h00);
    k = 2;
    while (!done0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("t2_done", done0, 1);
    check("t2_done_cycle", k, 209);
    check("t2_err", err0, 0);
    @(negedge clk);
    check_seq("t2_seq", obs0_q);

    // 3: all-NUL message
    en0 = en_cnt; er0 = err_cnt;
    start_msg('0);
    wait_end(1, 100, k);
    check("t3_done", done, 1);
    check("t3_done_cycle", k, 17);
    @(negedge clk);
    check("t3_no_en", en_cnt - en0, 0);
    check("t3_err_cnt", err_cnt - er0, 0);

    // 4: uart never acknowledges
    uart_off = 1'b1;
    en0 = en_cnt; dn0 = done_cnt;
    start_msg(MSG_A);
    @(negedge clk);
    check("t4_first_en", tx_en, 1);
    wait_end(2, 100, k);
    check("t4_err", err, 1);
    check("t4_err_cycle", k, 17);
    @(negedge clk);
    check("t4_en_cnt", en_cnt - en0, 1);
    check("t4_no_done", done_cnt - dn0, 0);
    check("t4_state", state, 0);
    uart_off = 1'b0;

    // 5: reset during the third byte's WAIT_DONE
    obs_q.delete();
    dn0 = done_cnt; er0 = err_cnt;
    start_msg(MSG_CALC);
    repeat (35) @(negedge clk);
    check("t5_in_wait_done", state, 3);
    check("t5_bytes_before", obs_q.size(), 3);
    resetn = 1'b0;
    #1;
    check("t5_rst_state", state, 0);
    check("t5_rst_tx_en", tx_en, 0);
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
    while (tx_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_uart_idle", tx_busy, 0);
    @(negedge clk);
    check("t5_no_pulse", (done_cnt - dn0) + (err_cnt - er0), 0);
    obs_q.delete(); load_exp(0);
    start_msg(MSG_CALC);
    wait_end(1, 400, k);
    check("t5_done", done, 1);
    @(negedge clk);
    check_seq("t5_seq", obs_q);

    // 6: uart held busy in SEND, extra start while active
    obs_q.delete(); load_exp(0);
    force_busy = 1'b1;
    en0 = en_cnt; dn0 = done_cnt;
    start_msg(MSG_CALC);
    repeat (10) @(negedge clk);
    start = 1'b1; data = MSG_A;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_en_busy", en_cnt - en0, 0);
    check("t6_state_send", state, 1);
    force_busy = 1'b0;
    wait_end(0, 400, k);
    check("t6_done", done, 1);
    @(negedge clk);
    check_seq("t6_seq", obs_q);
    check("t6_done_cnt", done_cnt - dn0, 1);
    check("t6_state_idle", state, 0);

    check("en_while_busy", en_while_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
